// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared definitions for the stopwatch control sequencer.
//   state_t   - FSM state encoding, also driven onto the LED state outputs
//   KEY_*     - bit positions of the individual push-buttons inside KEY
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    LAP   = 2'b10,
    PAUSE = 2'b11
  } state_t;

  localparam int KEY_START = 0;
  localparam int KEY_LAP   = 1;
  localparam int KEY_CLEAR = 2;

endpackage

// File: rtl/stopwatch_ctrl_key_debounce.sv
// key_debounce: conditions one raw active-low push-button.
//   i_clk    - system clock, rising edge
//   i_rst    - asynchronous active-high reset
//   i_key_n  - raw button level (0 = pressed), asynchronous to i_clk
//   o_press  - one-cycle pulse when the debounced level falls 1->0
// The debounced level only follows the synchronized input once it has
// disagreed with the current level for DEBOUNCE_CYCLES cycles in a row.
module key_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_n,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync0;
  logic          r_sync1;
  logic          r_level;
  logic          r_level_d;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync0   <= 1'b1;
      r_sync1   <= 1'b1;
      r_level   <= 1'b1;
      r_level_d <= 1'b1;
      r_press   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync0   <= i_key_n;
      r_sync1   <= r_sync0;
      r_level_d <= r_level;
      // Falling edge of the debounced level only; releases are silent.
      r_press   <= r_level_d & ~r_level;
      // Any cycle agreeing with the current level restarts the run.
      if (r_sync1 != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= r_sync1;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: start/stop/lap/clear sequencer for the BCD stopwatch.
//   CLOCK_50 - system clock, rising edge
//   reset    - asynchronous active-high reset
//   KEY[2:0] - raw active-low buttons: [0] start/stop, [1] lap, [2] clear
//   tick     - one-cycle increment enable to the BCD counter
//   clear    - one-cycle synchronous clear to the BCD counter
//   hold     - display latch frozen while high (LAP state)
//   state    - current FSM state, drives the LEDs
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV        = 500000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [2:0] KEY,
  output logic       tick,
  output logic       clear,
  output logic       hold,
  output logic [1:0] state
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [2:0]    w_press;
  logic          w_start;
  logic          w_lap;
  logic          w_clr;
  logic          w_counting;
  logic [PW-1:0] w_presc_inc;

  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic          r_tick;
  logic          r_clear;
  logic          r_hold;

  for (genvar g = 0; g < 3; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .i_clk  (CLOCK_50),
      .i_rst  (reset),
      .i_key_n(KEY[g]),
      .o_press(w_press[g])
    );
  end

  assign w_start     = w_press[KEY_START];
  assign w_lap       = w_press[KEY_LAP];
  assign w_clr       = w_press[KEY_CLEAR];
  assign w_counting  = (r_state == RUN) || (r_state == LAP);
  assign w_presc_inc = (r_presc == PRESC_LAST) ? '0 : r_presc + 1'b1;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_presc <= '0;
      r_tick  <= 1'b0;
      r_clear <= 1'b0;
      r_hold  <= 1'b0;
    end else begin
      r_tick  <= 1'b0;
      r_clear <= 1'b0;
      // Counting uses the pre-transition state, so a key event landing on
      // the wrap edge still delivers that tick. tick is high exactly while
      // the prescaler sits at its last value.
      if (w_counting) begin
        r_presc <= w_presc_inc;
        r_tick  <= (w_presc_inc == PRESC_LAST);
      end
      // Event priority within each state: clear > start > lap.
      case (r_state)
        IDLE: begin
          if (w_clr) begin
            r_clear <= 1'b1;
            r_presc <= '0;
          end else if (w_start) begin
            r_state <= RUN;
          end
        end
        RUN: begin
          if (w_start) begin
            r_state <= PAUSE;
          end else if (w_lap) begin
            r_state <= LAP;
            r_hold  <= 1'b1;
          end
        end
        LAP: begin
          if (w_start) begin
            r_state <= PAUSE;
            r_hold  <= 1'b0;
          end else if (w_lap) begin
            r_state <= RUN;
            r_hold  <= 1'b0;
          end
        end
        PAUSE: begin
          if (w_clr) begin
            r_clear <= 1'b1;
            r_presc <= '0;
            r_state <= IDLE;
          end else if (w_start) begin
            r_state <= RUN;
          end
        end
        default: begin
          r_state <= IDLE;
          r_hold  <= 1'b0;
        end
      endcase
    end
  end

  assign tick  = r_tick;
  assign clear = r_clear;
  assign hold  = r_hold;
  assign state = r_state;

endmodule
